// File: rtl/axis_checker_pkg.sv
// Shared definitions for the AXI4-Stream frame checker.
// Contents: checker FSM state type, tuser marker bit positions, error flag bit
// positions, and the tready pattern LFSR seed, tap mask and step function.
package axis_checker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StInLine,
    StGap
  } chk_state_e;

  // tuser marker bit positions
  localparam int unsigned UserSof = 0;
  localparam int unsigned UserEof = 1;
  localparam int unsigned UserSol = 2;
  localparam int unsigned UserEol = 3;

  // err_flags bit positions
  localparam int unsigned ErrSofInFrame   = 0;
  localparam int unsigned ErrOutsideFrame = 1;
  localparam int unsigned ErrLineLen      = 2;
  localparam int unsigned ErrLineCnt      = 3;
  localparam int unsigned ErrLastEol      = 4;
  localparam int unsigned NumErr          = 5;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting right.
  // Those taps land on state bits 0,2,3,5.
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {^(state & LfsrTaps), state[15:1]};
  endfunction

endpackage

// File: rtl/axis_stall_gen.sv
// Back-pressure pattern generator for the frame checker.
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   enable_i     0 forces tready low from the next cycle on
//   stall_mode_i 0/3 always ready, 1 alternate cycles, 2 LFSR bit 0
//   tready_o     registered ready; never depends on tvalid
module axis_stall_gen
  import axis_checker_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [1:0] stall_mode_i,
  output logic       tready_o
);

  logic [15:0] lfsr_q;
  logic        toggle_q;
  logic        tready_q;
  logic        pattern;

  always_comb begin
    pattern = 1'b1;
    unique case (stall_mode_i)
      2'd1:    pattern = ~toggle_q;  // first cycle after reset release is ready
      2'd2:    pattern = lfsr_q[0];
      default: pattern = 1'b1;
    endcase
  end

  // The LFSR and toggle run every cycle regardless of mode so that the pattern
  // phase is a pure function of cycles since reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q   <= LfsrSeed;
      toggle_q <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_next(lfsr_q);
      toggle_q <= ~toggle_q;
      tready_q <= enable_i & pattern;
    end
  end

  assign tready_o = tready_q;

endmodule

// File: rtl/axis_frame_checker.sv
// AXI4-Stream video sink that checks frame/line markers and geometry.
// Ports:
//   aclk, aclk_reset          clock, asynchronous active-high reset
//   s_axis_*                  AXI4-Stream slave (tuser: SOF, EOF, SOL, EOL)
//   cfg_enable                0 holds tready low and the FSM idle
//   cfg_stall_mode            back-pressure pattern select
//   cfg_exp_line_beats/lines  expected frame geometry
//   err_clear                 clears err_flags (a same-cycle set wins)
//   frame_done                one-cycle pulse after an EOF beat
//   frame_count               completed frames, wrapping
//   last_frame_lines          line count of the last completed frame
//   frame_checksum            XOR of all tdata beats of the last completed frame
//   err_flags                 sticky protocol error flags
module axis_frame_checker
  import axis_checker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aclk_reset,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  cfg_enable,
  input  logic [1:0]            cfg_stall_mode,
  input  logic [CNT_WIDTH-1:0]  cfg_exp_line_beats,
  input  logic [CNT_WIDTH-1:0]  cfg_exp_lines,
  input  logic                  err_clear,
  output logic                  frame_done,
  output logic [31:0]           frame_count,
  output logic [CNT_WIDTH-1:0]  last_frame_lines,
  output logic [DATA_WIDTH-1:0] frame_checksum,
  output logic [NumErr-1:0]     err_flags
);

  logic tready;

  axis_stall_gen u_stall_gen (
    .clk_i        (aclk),
    .rst_i        (aclk_reset),
    .enable_i     (cfg_enable),
    .stall_mode_i (cfg_stall_mode),
    .tready_o     (tready)
  );

  chk_state_e            state_q;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, line_cnt_q;
  logic [DATA_WIDTH-1:0] csum_q;
  logic                  frame_done_q;
  logic [31:0]           frame_count_q;
  logic [CNT_WIDTH-1:0]  last_lines_q;
  logic [DATA_WIDTH-1:0] frame_csum_q;
  logic [NumErr-1:0]     err_q;

  logic                  beat_fire;
  logic                  sof, eof, sol, eol;
  logic                  is_start, is_new_line, is_cont, is_data, line_end;
  logic [CNT_WIDTH-1:0]  beats_base, lines_base, beats_new, lines_new;
  logic [DATA_WIDTH-1:0] csum_new;
  logic [NumErr-1:0]     err_set;

  always_comb begin
    // A beat that slips through while enable drops is ignored, like the FSM.
    beat_fire = s_axis_tvalid & tready & cfg_enable;
    sof = s_axis_tuser[UserSof];
    eof = s_axis_tuser[UserEof];
    sol = s_axis_tuser[UserSol];
    eol = s_axis_tuser[UserEol];

    // Classify the beat; every accepted data beat is then treated as a line beat.
    is_start    = (state_q == StIdle) ? (sof & sol) : sof;
    is_new_line = (state_q == StGap) & ~sof & sol;
    is_cont     = (state_q == StInLine) & ~sof;
    is_data     = is_start | is_new_line | is_cont;
    line_end    = s_axis_tlast | eof;

    beats_base = is_cont ? beat_cnt_q : '0;
    lines_base = is_start ? '0 : line_cnt_q;
    csum_new   = (is_start ? '0 : csum_q) ^ s_axis_tdata;
    // Saturating counters guarantee a mismatch once the range is exhausted.
    beats_new  = (&beats_base) ? beats_base : beats_base + CNT_WIDTH'(1);
    lines_new  = (&lines_base) ? lines_base : lines_base + CNT_WIDTH'(1);

    err_set = '0;
    if (beat_fire) begin
      err_set[ErrLastEol]      = s_axis_tlast ^ eol;
      err_set[ErrSofInFrame]   = sof & (state_q != StIdle);
      err_set[ErrOutsideFrame] = ~is_data;
      if (is_data && line_end) begin
        err_set[ErrLineLen] = (beats_new != cfg_exp_line_beats);
        err_set[ErrLineCnt] = eof & (lines_new != cfg_exp_lines);
      end
    end
  end

  always_ff @(posedge aclk or posedge aclk_reset) begin
    if (aclk_reset) begin
      state_q       <= StIdle;
      beat_cnt_q    <= '0;
      line_cnt_q    <= '0;
      csum_q        <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      last_lines_q  <= '0;
      frame_csum_q  <= '0;
      err_q         <= '0;
    end else begin
      frame_done_q <= 1'b0;
      err_q        <= (err_clear ? '0 : err_q) | err_set;
      if (!cfg_enable) begin
        state_q <= StIdle;
      end else if (beat_fire && is_data) begin
        beat_cnt_q <= beats_new;
        csum_q     <= csum_new;
        if (line_end) begin
          line_cnt_q <= lines_new;
          if (eof) begin
            frame_done_q  <= 1'b1;
            frame_count_q <= frame_count_q + 32'd1;
            last_lines_q  <= lines_new;
            frame_csum_q  <= csum_new;
            state_q       <= StIdle;
          end else begin
            state_q <= StGap;
          end
        end else begin
          line_cnt_q <= lines_base;
          state_q    <= StInLine;
        end
      end
    end
  end

  assign s_axis_tready    = tready;
  assign frame_done       = frame_done_q;
  assign frame_count      = frame_count_q;
  assign last_frame_lines = last_lines_q;
  assign frame_checksum   = frame_csum_q;
  assign err_flags        = err_q;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Self-checking bench for axis_frame_checker: a frame-level reference model
// predicts every registered output each cycle; directed scenarios add literal
// expectations on top of the model.
module tb_axis_frame_checker;

  localparam int DW = 64;
  localparam int UW = 4;
  localparam int CW = 16;

  logic          tb_CLK = 1'b0;
  logic          aclk_reset;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tlast;
  logic [UW-1:0] s_axis_tuser;
  logic          cfg_enable;
  logic [1:0]    cfg_stall_mode;
  logic [CW-1:0] cfg_exp_line_beats;
  logic [CW-1:0] cfg_exp_lines;
  logic          err_clear;
  logic          frame_done;
  logic [31:0]   frame_count;
  logic [CW-1:0] last_frame_lines;
  logic [DW-1:0] frame_checksum;
  logic [4:0]    err_flags;

  always #5 tb_CLK = ~tb_CLK;

  axis_frame_checker #(
    .DATA_WIDTH (DW),
    .USER_WIDTH (UW),
    .CNT_WIDTH  (CW)
  ) dut (
    .aclk               (tb_CLK),
    .aclk_reset         (aclk_reset),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tlast       (s_axis_tlast),
    .s_axis_tuser       (s_axis_tuser),
    .cfg_enable         (cfg_enable),
    .cfg_stall_mode     (cfg_stall_mode),
    .cfg_exp_line_beats (cfg_exp_line_beats),
    .cfg_exp_lines      (cfg_exp_lines),
    .err_clear          (err_clear),
    .frame_done         (frame_done),
    .frame_count        (frame_count),
    .last_frame_lines   (last_frame_lines),
    .frame_checksum     (frame_checksum),
    .err_flags          (err_flags)
  );

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;
  int gap_pct = 0;
  bit seq_data = 0;
  int unsigned dcount = 0;

  // ---------------- reference model ----------------
  logic          m_tready = 1'b0;
  int unsigned   m_k = 0;
  logic [15:0]   m_lfsr = 16'hACE1;
  bit            m_in_frame = 0;
  bit            m_in_line = 0;
  int            m_lens[$];
  int            m_cur = 0;
  logic [DW-1:0] m_xor = '0;
  logic          exp_done = 1'b0;
  logic [31:0]   exp_count = '0;
  logic [CW-1:0] exp_lines = '0;
  logic [DW-1:0] exp_csum = '0;
  logic [4:0]    exp_err = '0;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, req);
    end
  endtask

  // One accepted beat, judged by the frame/line rules.
  task automatic model_beat(output logic [4:0] set);
    bit sof, eof, sol, eol, last, data_ok;
    sof  = s_axis_tuser[0];
    eof  = s_axis_tuser[1];
    sol  = s_axis_tuser[2];
    eol  = s_axis_tuser[3];
    last = s_axis_tlast;
    set  = '0;
    data_ok = 1;
    if (last != eol) set[4] = 1'b1;
    if (sof && m_in_frame) set[0] = 1'b1;
    if (sof && (m_in_frame || sol)) begin
      m_lens.delete();
      m_cur = 0;
      m_xor = '0;
      m_in_frame = 1;
      m_in_line = 1;
    end else if (m_in_frame && !m_in_line && sol) begin
      m_cur = 0;
      m_in_line = 1;
    end else if (!(m_in_frame && m_in_line)) begin
      set[1] = 1'b1;
      data_ok = 0;
    end
    if (data_ok) begin
      m_cur++;
      m_xor ^= s_axis_tdata;
      if (last || eof) begin
        m_lens.push_back(m_cur);
        if (sat(m_cur) != int'(cfg_exp_line_beats)) set[2] = 1'b1;
        m_in_line = 0;
        if (eof) begin
          if (sat(m_lens.size()) != int'(cfg_exp_lines)) set[3] = 1'b1;
          exp_done  = 1'b1;
          exp_count = exp_count + 32'd1;
          exp_lines = CW'(sat(m_lens.size()));
          exp_csum  = m_xor;
          m_in_frame = 0;
        end
      end
    end
  endtask

  task automatic model_step();
    logic [4:0] set;
    logic p;
    if (aclk_reset) begin
      m_tready = 1'b0; m_k = 0; m_lfsr = 16'hACE1;
      m_in_frame = 0; m_in_line = 0; m_lens.delete(); m_cur = 0; m_xor = '0;
      exp_done = 1'b0; exp_count = '0; exp_lines = '0; exp_csum = '0; exp_err = '0;
      return;
    end
    set = '0;
    exp_done = 1'b0;
    if (!cfg_enable) begin
      m_in_frame = 0;
      m_in_line = 0;
    end else if (s_axis_tvalid && m_tready) begin
      model_beat(set);
    end
    exp_err = (err_clear ? 5'b0 : exp_err) | set;
    m_k++;
    case (cfg_stall_mode)
      2'd1:    p = m_k[0];
      2'd2:    p = m_lfsr[0];
      default: p = 1'b1;
    endcase
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    m_tready = cfg_enable && p;
  endtask

  initial forever begin
    @(posedge tb_CLK);
    model_step();
  end

  // Compare every cycle on the falling edge, away from DUT updates.
  initial forever begin
    @(negedge tb_CLK);
    chk("tready", 64'(s_axis_tready), 64'(m_tready));
    chk("frame_done", 64'(frame_done), 64'(exp_done));
    chk("frame_count", 64'(frame_count), 64'(exp_count));
    chk("last_frame_lines", 64'(last_frame_lines), 64'(exp_lines));
    chk("frame_checksum", frame_checksum, exp_csum);
    chk("err_flags", 64'(err_flags), 64'(exp_err));
    if (frame_done) done_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge tb_CLK);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [3:0] u, input logic l);
    int n;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    n = 0;
    while (!s_axis_tready && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout at %0t: got tready low for %0d cycles, want a transfer", $time, n);
    end
    tick();
    s_axis_tvalid = 1'b0;
    if (gap_pct > 0 && $urandom_range(99) < gap_pct) repeat ($urandom_range(3, 1)) tick();
  endtask

  function automatic logic [DW-1:0] next_data();
    dcount++;
    return seq_data ? DW'(dcount) : {$urandom, $urandom};
  endfunction

  task automatic send_frame(input int nb, input int nl, input int bad_line, input int bad_len);
    int len;
    logic [3:0] u;
    for (int ln = 0; ln < nl; ln++) begin
      len = (ln == bad_line) ? bad_len : nb;
      for (int b = 0; b < len; b++) begin
        u = '0;
        u[0] = (ln == 0 && b == 0);
        u[1] = (ln == nl - 1 && b == len - 1);
        u[2] = (b == 0);
        u[3] = (b == len - 1);
        send_beat(next_data(), u, b == len - 1);
      end
    end
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  task automatic set_geom(input int nb, input int nl);
    cfg_exp_line_beats = CW'(nb);
    cfg_exp_lines      = CW'(nl);
  endtask

  initial begin
    int nb, nl, bad, bad_len;
    aclk_reset = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_tuser = '0;
    cfg_enable = 1'b1; cfg_stall_mode = 2'd0; err_clear = 1'b0;
    set_geom(4, 3);
    repeat (3) tick();
    chk("reset_tready", 64'(s_axis_tready), 64'd0);
    chk("reset_count", 64'(frame_count), 64'd0);
    chk("reset_csum", frame_checksum, 64'd0);
    chk("reset_err", 64'(err_flags), 64'd0);
    aclk_reset = 1'b0;
    repeat (2) tick();

    // Clean 4x3 frame with data 1..12: XOR of 1..12 is 12.
    seq_data = 1; dcount = 0;
    send_frame(4, 3, -1, 0);
    seq_data = 0;
    repeat (2) tick();
    chk("t1_pulses", 64'(done_pulses), 64'd1);
    chk("t1_count", 64'(frame_count), 64'd1);
    chk("t1_lines", 64'(last_frame_lines), 64'd3);
    chk("t1_csum", frame_checksum, 64'd12);
    chk("t1_model_csum", exp_csum, 64'd12);
    chk("t1_err", 64'(err_flags), 64'd0);

    // LFSR back-pressure, 10 back-to-back 8x5 frames.
    cfg_stall_mode = 2'd2;
    set_geom(8, 5);
    for (int f = 0; f < 10; f++) send_frame(8, 5, -1, 0);
    repeat (2) tick();
    chk("t2_count", 64'(frame_count), 64'd11);
    chk("t2_lines", 64'(last_frame_lines), 64'd5);
    chk("t2_err", 64'(err_flags), 64'd0);

    // Short second line.
    cfg_stall_mode = 2'd0;
    set_geom(4, 3);
    send_frame(4, 3, 1, 3);
    tick();
    chk("t3_err", 64'(err_flags), 64'h04);
    chk("t3_count", 64'(frame_count), 64'd12);
    clear_err();
    chk("t3_cleared", 64'(err_flags), 64'd0);

    // SOF mid-line aborts the partial frame.
    for (int b = 0; b < 4; b++)
      send_beat(next_data(), (b == 0) ? 4'b0101 : ((b == 3) ? 4'b1000 : 4'b0000), b == 3);
    send_beat(next_data(), 4'b0100, 1'b0);
    send_beat(next_data(), 4'b0000, 1'b0);
    send_frame(4, 3, -1, 0);
    tick();
    chk("t4_err", 64'(err_flags), 64'h01);
    chk("t4_count", 64'(frame_count), 64'd13);
    chk("t4_pulses", 64'(done_pulses), 64'd13);
    clear_err();
    send_frame(4, 3, -1, 0);
    tick();
    chk("t4_clean_err", 64'(err_flags), 64'd0);
    chk("t4_clean_count", 64'(frame_count), 64'd14);

    // tlast without EOL, then clear colliding with new err[1]/err[4] events.
    set_geom(4, 1);
    send_beat(next_data(), 4'b0101, 1'b0);
    send_beat(next_data(), 4'b0000, 1'b0);
    send_beat(next_data(), 4'b0000, 1'b0);
    send_beat(next_data(), 4'b0010, 1'b1);
    tick();
    chk("t5_err", 64'(err_flags), 64'h10);
    chk("t5_count", 64'(frame_count), 64'd15);
    err_clear = 1'b1;
    send_beat(next_data(), 4'b0000, 1'b1);
    err_clear = 1'b0;
    chk("t5_clear_collide", 64'(err_flags), 64'h12);

    // Enable dropped mid-frame.
    clear_err();
    set_geom(4, 3);
    send_beat(next_data(), 4'b0101, 1'b0);
    send_beat(next_data(), 4'b0000, 1'b0);
    cfg_enable = 1'b0;
    repeat (2) tick();
    chk("t6_tready_off", 64'(s_axis_tready), 64'd0);
    cfg_enable = 1'b1;
    tick();
    send_frame(4, 3, -1, 0);
    tick();
    chk("t6_err", 64'(err_flags), 64'd0);
    chk("t6_count", 64'(frame_count), 64'd16);

    // Reset mid-frame.
    send_beat(next_data(), 4'b0101, 1'b0);
    send_beat(next_data(), 4'b0000, 1'b0);
    aclk_reset = 1'b1;
    repeat (2) tick();
    chk("t7_count", 64'(frame_count), 64'd0);
    chk("t7_lines", 64'(last_frame_lines), 64'd0);
    chk("t7_tready", 64'(s_axis_tready), 64'd0);
    aclk_reset = 1'b0;
    tick();
    send_frame(4, 3, -1, 0);
    tick();
    chk("t7_after_count", 64'(frame_count), 64'd1);
    chk("t7_after_err", 64'(err_flags), 64'd0);
    chk("t7_pulses", 64'(done_pulses), 64'd17);

    // Random geometry, stall modes, idle gaps and occasional bad lines.
    gap_pct = 30;
    for (int f = 0; f < 20; f++) begin
      nb = $urandom_range(6, 1);
      nl = $urandom_range(4, 1);
      cfg_stall_mode = 2'($urandom_range(3));
      set_geom(nb, nl);
      bad = ($urandom_range(4) == 0) ? $urandom_range(nl - 1) : -1;
      bad_len = $urandom_range(nb + 1, 1);
      send_frame(nb, nl, bad, bad_len);
      if ($urandom_range(3) == 0) clear_err();
    end
    repeat (3) tick();
    chk("rand_count", 64'(frame_count), 64'd21);
    chk("rand_pulses", 64'(done_pulses), 64'd37);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
